// File: rtl/demux1_2_stream.sv
// Registered 1-to-2 stream demultiplexer with per-packet channel lock.
// Optional packet counters are built when DEMUX1_2_STATS_EN is defined.
module demux1_2_stream #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
`ifdef DEMUX1_2_STATS_EN
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1,
`endif
    output logic [1:0]       o_dbg_state
);

    // Handshake: a beat transfers on a rising edge where valid && ready;
    // valid never waits on ready, and held data is stable while valid && !ready.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_target;
    logic              w_target_free;
    logic              w_accept;

    logic              r_out0_valid;
    logic [WIDTH-1:0]  r_out0_data;
    logic              r_out0_last;
    logic              r_out1_valid;
    logic [WIDTH-1:0]  r_out1_data;
    logic              r_out1_last;

    // in_sel only matters on a packet's first beat; afterwards the state holds the route.
    always_comb begin
        w_target = 1'b0;
        case (r_state)
            IDLE:    w_target = in_sel;
            ROUTE0:  w_target = 1'b0;
            ROUTE1:  w_target = 1'b1;
            default: w_target = 1'b0;
        endcase
    end

    assign w_target_free = w_target ? (!r_out1_valid || out1_ready)
                                    : (!r_out0_valid || out0_ready);
    assign in_ready = !reset && w_target_free;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !in_last) begin
                    w_state_nxt = in_sel ? ROUTE1 : ROUTE0;
                end
            end
            ROUTE0, ROUTE1: begin
                if (w_accept && in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A load on a draining slot wins, keeping valid high for back-to-back beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out0_valid <= 1'b0;
            r_out0_data  <= '0;
            r_out0_last  <= 1'b0;
        end else if (w_accept && !w_target) begin
            r_out0_valid <= 1'b1;
            r_out0_data  <= in_data;
            r_out0_last  <= in_last;
        end else if (out0_ready) begin
            r_out0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out1_valid <= 1'b0;
            r_out1_data  <= '0;
            r_out1_last  <= 1'b0;
        end else if (w_accept && w_target) begin
            r_out1_valid <= 1'b1;
            r_out1_data  <= in_data;
            r_out1_last  <= in_last;
        end else if (out1_ready) begin
            r_out1_valid <= 1'b0;
        end
    end

    assign out0_valid  = r_out0_valid;
    assign out0_data   = r_out0_data;
    assign out0_last   = r_out0_last;
    assign out1_valid  = r_out1_valid;
    assign out1_data   = r_out1_data;
    assign out1_last   = r_out1_last;
    assign o_dbg_state = r_state;

`ifdef DEMUX1_2_STATS_EN
    logic [15:0] r_pkt_cnt0;
    logic [15:0] r_pkt_cnt1;

    // Counters saturate rather than wrap so a long run never reports a small count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else if (w_accept && in_last) begin
            if (!w_target && r_pkt_cnt0 != 16'hFFFF) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
            end
            if (w_target && r_pkt_cnt1 != 16'hFFFF) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
            end
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed bench for demux1_2_stream; counter checks build only with DEMUX1_2_STATS_EN.
module tb_demux1_2_stream;

    localparam int W = 64;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          in_sel;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out0_data;
    logic          out0_last;
    logic          out1_valid;
    logic          out1_ready;
    logic [W-1:0]  out1_data;
    logic          out1_last;
    logic [1:0]    dbg_state;
`ifdef DEMUX1_2_STATS_EN
    logic [15:0]   pkt_cnt0;
    logic [15:0]   pkt_cnt1;
`endif

    int n_cmp;
    int n_fail;

    demux1_2_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
`ifdef DEMUX1_2_STATS_EN
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1),
`endif
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic last, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = sel;
        in_last  = last;
        in_data  = d;
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        step();

        // Reset state
        check("rst_out0_valid", W'(out0_valid), W'(0));
        check("rst_out1_valid", W'(out1_valid), W'(0));
        check("rst_out0_data",  out0_data, '0);
        check("rst_out1_last",  W'(out1_last), W'(0));
        check("rst_in_ready",   W'(in_ready), W'(0));
        check("rst_state",      W'(dbg_state), W'(0));
        reset = 1'b0;
        #1;
        check("idle_in_ready", W'(in_ready), W'(1));

        // Single beat to channel 1
        drive(1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        check("single_out1_valid", W'(out1_valid), W'(1));
        check("single_out1_data",  out1_data, 64'hDEAD_BEEF);
        check("single_out1_last",  W'(out1_last), W'(1));
        check("single_out0_valid", W'(out0_valid), W'(0));
        check("single_state",      W'(dbg_state), W'(0));
        step();
        check("single_drained", W'(out1_valid), W'(0));

        // Packet lock: in_sel toggles after the first beat but the route stays on 0
        drive(1'b1, 1'b0, 1'b0, 64'h11);
        step();
        check("lock_b0_data",  out0_data, 64'h11);
        check("lock_b0_last",  W'(out0_last), W'(0));
        check("lock_b0_state", W'(dbg_state), W'(1));
        drive(1'b1, 1'b1, 1'b0, 64'h22);
        step();
        check("lock_b1_data",  out0_data, 64'h22);
        check("lock_b1_valid", W'(out0_valid), W'(1));
        check("lock_b1_last",  W'(out0_last), W'(0));
        check("lock_b1_out1",  W'(out1_valid), W'(0));
        drive(1'b1, 1'b1, 1'b1, 64'h33);
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        check("lock_b2_data",  out0_data, 64'h33);
        check("lock_b2_last",  W'(out0_last), W'(1));
        check("lock_b2_out1",  W'(out1_valid), W'(0));
        check("lock_b2_state", W'(dbg_state), W'(0));
        step();
        check("lock_drained", W'(out0_valid), W'(0));

        // Backpressure on the targeted channel
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 64'h44);
        step();
        check("bp_load_data", out0_data, 64'h44);
        drive(1'b1, 1'b1, 1'b1, 64'h55);
        #1;
        check("bp_in_ready_low", W'(in_ready), W'(0));
        step();
        check("bp_hold_data",  out0_data, 64'h44);
        check("bp_hold_last",  W'(out0_last), W'(0));
        check("bp_hold_valid", W'(out0_valid), W'(1));
        check("bp_hold_state", W'(dbg_state), W'(1));
        out0_ready = 1'b1;
        #1;
        check("bp_in_ready_high", W'(in_ready), W'(1));
        step();
        check("bp_swap_valid", W'(out0_valid), W'(1));
        check("bp_swap_data",  out0_data, 64'h55);
        check("bp_swap_last",  W'(out0_last), W'(1));
        check("bp_swap_out1",  W'(out1_valid), W'(0));
        check("bp_swap_state", W'(dbg_state), W'(0));

        // Independence: channel 0 stalled and full, channel 1 streams
        drive(1'b0, 1'b0, 1'b0, '0);
        out0_ready = 1'b0;
        step();
        check("ind_out0_held", out0_data, 64'h55);
        drive(1'b1, 1'b1, 1'b1, 64'h66);
        #1;
        check("ind_in_ready_a", W'(in_ready), W'(1));
        step();
        check("ind_out1_a", out1_data, 64'h66);
        drive(1'b1, 1'b1, 1'b1, 64'h77);
        #1;
        check("ind_in_ready_b", W'(in_ready), W'(1));
        step();
        check("ind_out1_b",       out1_data, 64'h77);
        check("ind_out1_valid_b", W'(out1_valid), W'(1));
        check("ind_out0_still",   out0_data, 64'h55);
        check("ind_out0_valid",   W'(out0_valid), W'(1));
        drive(1'b1, 1'b0, 1'b1, 64'h7F);
        #1;
        check("ind_sel0_blocked", W'(in_ready), W'(0));

        // Reset in the middle of a channel-1 packet
        drive(1'b1, 1'b1, 1'b0, 64'h88);
        out1_ready = 1'b1;
        step();
        check("rmp_state_route1", W'(dbg_state), W'(2));
        check("rmp_out1_valid",   W'(out1_valid), W'(1));
        drive(1'b0, 1'b0, 1'b0, '0);
        out1_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rmp_in_ready_rst", W'(in_ready), W'(0));
        step();
        check("rmp_out1_cleared", W'(out1_valid), W'(0));
        check("rmp_out0_cleared", W'(out0_valid), W'(0));
        check("rmp_state_idle",   W'(dbg_state), W'(0));
        check("rmp_out1_data",    out1_data, '0);
        reset      = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 64'h99);
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        check("rmp_new_out0_valid", W'(out0_valid), W'(1));
        check("rmp_new_out0_data",  out0_data, 64'h99);
        check("rmp_new_out1_valid", W'(out1_valid), W'(0));

`ifdef DEMUX1_2_STATS_EN
        // Counters were cleared by the reset above; 0x99 is the first ch0 packet
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'($urandom_range(0, 255)));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, W'($urandom_range(0, 255)));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        check("stats_cnt0", W'(pkt_cnt0), W'(5));
        check("stats_cnt1", W'(pkt_cnt1), W'(2));
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 1'b1, '0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        check("stats_sat0", W'(pkt_cnt0), W'(16'hFFFF));
        check("stats_cnt1_kept", W'(pkt_cnt1), W'(2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
